// File: rtl/img_pkg.sv
// img_pkg: frame geometry, FSM state encoding and tile helpers shared by the tile fetch controller
package img_pkg;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int TILE  = 4;
    localparam int PIX_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Slot of pixel (dx,dy) inside the 4x4 tile: 4*dy + dx.
    function automatic logic [3:0] idx(input logic [1:0] dx, input logic [1:0] dy);
        return {dy, dx};
    endfunction

    // row*IMG_W as a sum of shifted rows, one term per set bit of IMG_W
    // (for 640 this folds to (row<<9)+(row<<7)).
    function automatic logic [21:0] row_off(input logic [8:0] row);
        logic [21:0] acc;
        acc = '0;
        for (int i = 0; i < 22; i++)
            if (IMG_W[i]) acc = acc + (22'(row) << i);
        return acc;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: tile origin latch, range check and row-major read address walk for one 4x4 tile
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_latch        : capture i_row/i_col as the tile origin
//   i_init         : compute line_base from the origin and clear dx/dy
//   i_step         : advance to the next pixel after an accepted read
//   o_range_err    : latched tile would extend past the frame edge
//   o_addr         : word address of the current pixel (line_base + dx)
//   o_dx, o_dy     : current pixel position inside the tile
//   o_last         : current pixel is the final one (dx=3, dy=3)
module tile_addr_gen
    import img_pkg::*;
#(
    parameter int BASE_ADDR = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_latch,
    input  logic [8:0]  i_row,
    input  logic [9:0]  i_col,
    input  logic        i_init,
    input  logic        i_step,
    output logic        o_range_err,
    output logic [21:0] o_addr,
    output logic [1:0]  o_dx,
    output logic [1:0]  o_dy,
    output logic        o_last
);

    logic [8:0]  r_row;
    logic [9:0]  r_col;
    logic [21:0] r_line_base;
    logic [1:0]  r_dx;
    logic [1:0]  r_dy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_line_base <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
        end else begin
            if (i_latch) begin
                r_row <= i_row;
                r_col <= i_col;
            end
            if (i_init) begin
                r_line_base <= 22'(BASE_ADDR) + row_off(r_row) + 22'(r_col);
                r_dx        <= '0;
                r_dy        <= '0;
            end else if (i_step) begin
                // dx wraps 3->0 on its own; the end of a tile row moves down one frame line
                r_dx <= r_dx + 2'd1;
                if (r_dx == 2'd3) begin
                    r_dy        <= r_dy + 2'd1;
                    r_line_base <= r_line_base + 22'(IMG_W);
                end
            end
        end
    end

    assign o_range_err = (({1'b0, r_row} + 10'(TILE)) > 10'(IMG_H)) ||
                         (({1'b0, r_col} + 11'(TILE)) > 11'(IMG_W));
    assign o_addr      = r_line_base + 22'(r_dx);
    assign o_dx        = r_dx;
    assign o_dy        = r_dy;
    assign o_last      = &{r_dx, r_dy};

endmodule

// File: rtl/hps_tile_fetch_ctrl.sv
// hps_tile_fetch_ctrl: HPS start/done handshake that reads a 4x4 pixel tile from the frame buffer
//   iCLK, iRST_N          : clock, synchronous active-low reset
//   iSTART                : HPS start level (already synchronised); a rising edge in IDLE starts a fetch
//   iROW, iCOL            : tile top-left pixel
//   oMEM_RD, oMEM_ADDR    : one-cycle read strobe and word address
//   iMEM_DATA, iMEM_VALID : read return, one or more cycles after the strobe
//   oTILE                 : 16 pixels, pixel k = 4*dy+dx at [16k+15:16k]
//   oDONE, oERR           : fetch finished / failed (range or timeout); held until iSTART drops
//   oBUSY, oSTATE         : not-idle flag and raw state code for the HPS state PIO
module hps_tile_fetch_ctrl
    import img_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iSTART,
    input  logic [8:0]   iROW,
    input  logic [9:0]   iCOL,
    output logic         oMEM_RD,
    output logic [21:0]  oMEM_ADDR,
    input  logic [15:0]  iMEM_DATA,
    input  logic         iMEM_VALID,
    output logic [255:0] oTILE,
    output logic         oDONE,
    output logic         oERR,
    output logic         oBUSY,
    output logic [2:0]   oSTATE
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t         r_state;
    logic           r_start_q;
    logic [TW-1:0]  r_tmo;
    logic [255:0]   r_tile;
    logic           r_done;
    logic           r_err;

    logic           w_start_edge;
    logic           w_range_err;
    logic [21:0]    w_addr;
    logic [1:0]     w_dx;
    logic [1:0]     w_dy;
    logic           w_last;

    assign w_start_edge = iSTART & ~r_start_q;

    tile_addr_gen #(.BASE_ADDR(BASE_ADDR)) u_addr (
        .i_clk       (iCLK),
        .i_rst_n     (iRST_N),
        .i_latch     ((r_state == S_IDLE) && w_start_edge),
        .i_row       (iROW),
        .i_col       (iCOL),
        .i_init      (r_state == S_CHECK),
        .i_step      ((r_state == S_WAIT) && iMEM_VALID),
        .o_range_err (w_range_err),
        .o_addr      (w_addr),
        .o_dx        (w_dx),
        .o_dy        (w_dy),
        .o_last      (w_last)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            // Tracking iSTART through reset means a level held across reset exit is not an edge.
            r_start_q <= iSTART;
            r_tmo     <= '0;
            r_tile    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_q <= iSTART;
            case (r_state)
                S_IDLE:
                    if (w_start_edge) r_state <= S_CHECK;
                S_CHECK:
                    if (w_range_err) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                S_ISSUE: begin
                    r_tmo   <= TW'(TIMEOUT);
                    r_state <= S_WAIT;
                end
                S_WAIT:
                    if (iMEM_VALID) begin
                        r_tile[{idx(w_dx, w_dy), 4'd0} +: PIX_W] <= iMEM_DATA;
                        r_done  <= w_last;
                        r_state <= w_last ? S_DONE : S_ISSUE;
                    end else if (r_tmo <= TW'(1)) begin
                        // Last allowed wait cycle passed with no data: abandon, keep filled slots.
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                S_DONE:
                    if (!iSTART) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

    assign oMEM_RD   = (r_state == S_ISSUE);
    assign oMEM_ADDR = oMEM_RD ? w_addr : '0;
    assign oTILE     = r_tile;
    assign oDONE     = r_done;
    assign oERR      = r_err;
    assign oBUSY     = (r_state != S_IDLE);
    assign oSTATE    = r_state;

endmodule

// File: tb/tb_hps_tile_fetch_ctrl.sv
// tb_hps_tile_fetch_ctrl: directed vector table plus hand-written corner sequences for the tile fetch controller
module tb_hps_tile_fetch_ctrl;

    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic         iSTART = 1'b0;
    logic [8:0]   iROW = '0;
    logic [9:0]   iCOL = '0;
    logic [15:0]  iMEM_DATA = '0;
    logic         iMEM_VALID = 1'b0;
    logic         oMEM_RD;
    logic [21:0]  oMEM_ADDR;
    logic [255:0] oTILE;
    logic         oDONE, oERR, oBUSY;
    logic [2:0]   oSTATE;

    hps_tile_fetch_ctrl dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iROW(iROW), .iCOL(iCOL),
        .oMEM_RD(oMEM_RD), .oMEM_ADDR(oMEM_ADDR), .iMEM_DATA(iMEM_DATA), .iMEM_VALID(iMEM_VALID),
        .oTILE(oTILE), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY), .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    int cyc_n = 0;
    always @(posedge iCLK) cyc_n <= cyc_n + 1;

    // Memory model: returns addr[15:0] after a fixed or random latency, can drop one response.
    int  mem_lat = 1;
    bit  mem_rand = 1'b0;
    int  drop_at = -1;
    int  rd_total = 0;
    int  ovl_cnt = 0;
    int  drop_cyc = 0;
    int  last_addr = 0;
    bit  pending = 1'b0;
    int  pend_cnt = 0;
    logic [15:0] pend_data = '0;

    always @(negedge iCLK) begin
        iMEM_VALID = 1'b0;
        if (pending) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                pending    = 1'b0;
                iMEM_VALID = 1'b1;
                iMEM_DATA  = pend_data;
            end
        end
        if (oMEM_RD) begin
            if (pending) ovl_cnt = ovl_cnt + 1;
            rd_total  = rd_total + 1;
            last_addr = int'(oMEM_ADDR);
            if (rd_total == drop_at) begin
                drop_cyc = cyc_n;
            end else begin
                pending   = 1'b1;
                pend_cnt  = mem_rand ? int'($urandom_range(1, 20)) : mem_lat;
                pend_data = oMEM_ADDR[15:0];
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] model_tile(input int r, input int c);
        logic [255:0] t;
        int a;
        t = '0;
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++) begin
                a = (r + dy) * 640 + c + dx;
                t[(4*dy + dx)*16 +: 16] = a[15:0];
            end
        return t;
    endfunction

    task automatic do_fetch(input int r, input int c, output int cyc);
        iROW   = 9'(r);
        iCOL   = 10'(c);
        iSTART = 1'b1;
        cyc    = 0;
        while (!oDONE && cyc < 6000) begin
            @(negedge iCLK);
            cyc++;
        end
    endtask

    typedef struct {
        int   row;
        int   col;
        logic err;
        int   cyc;
        int   rds;
        int   last;
    } vec_t;

    vec_t vt[8];
    logic [255:0] exp_tile;
    logic [255:0] t;
    int cyc, rd0, ovl0, r, c, dcyc;

    initial begin
        vt[0] = '{2,   5,   1'b0, 34, 16, 3208};
        vt[1] = '{476, 636, 1'b0, 34, 16, 307199};
        vt[2] = '{477, 0,   1'b1, 2,  0,  0};
        vt[3] = '{0,   637, 1'b1, 2,  0,  0};
        vt[4] = '{0,   0,   1'b0, 34, 16, 1923};
        vt[5] = '{477, 637, 1'b1, 2,  0,  0};
        vt[6] = '{479, 639, 1'b1, 2,  0,  0};
        vt[7] = '{100, 300, 1'b0, 34, 16, 66223};
        exp_tile = '0;

        // reset with iSTART held high: no fetch on reset exit
        iSTART = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (5) @(negedge iCLK);
        chk("reset_busy", oBUSY, 0);
        chk("reset_state", oSTATE, 0);
        chk("reset_flags", {oDONE, oERR, oMEM_RD}, 0);
        chk("reset_tile", oTILE, 0);
        chk("reset_no_reads", rd_total, 0);
        iSTART = 1'b0;
        @(negedge iCLK);

        foreach (vt[i]) begin
            rd0 = rd_total;
            ovl0 = ovl_cnt;
            do_fetch(vt[i].row, vt[i].col, cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_err", i), oERR, vt[i].err);
            chk($sformatf("v%0d_done", i), oDONE, 1);
            chk($sformatf("v%0d_reads", i), rd_total - rd0, vt[i].rds);
            if (!vt[i].err) begin
                exp_tile = model_tile(vt[i].row, vt[i].col);
                chk($sformatf("v%0d_last_addr", i), last_addr, vt[i].last);
            end
            chk($sformatf("v%0d_tile", i), oTILE, exp_tile);
            chk($sformatf("v%0d_outstanding", i), ovl_cnt - ovl0, 0);
            iSTART = 1'b0;
            @(negedge iCLK);
            chk($sformatf("v%0d_done_clear", i), {oDONE, oERR, oSTATE}, 0);
        end

        // variable latency, random tiles
        mem_rand = 1'b1;
        ovl0 = ovl_cnt;
        for (int k = 0; k < 50; k++) begin
            r = int'($urandom_range(0, 476));
            c = int'($urandom_range(0, 636));
            do_fetch(r, c, cyc);
            exp_tile = model_tile(r, c);
            chk($sformatf("rnd%0d_done_ok", k), {oDONE, oERR}, 2'b10);
            chk($sformatf("rnd%0d_tile", k), oTILE, exp_tile);
            iSTART = 1'b0;
            @(negedge iCLK);
        end
        chk("rnd_outstanding", ovl_cnt - ovl0, 0);
        mem_rand = 1'b0;
        mem_lat = 1;

        // timeout: 7th response dropped
        drop_at = rd_total + 7;
        do_fetch(10, 20, cyc);
        dcyc = cyc_n - drop_cyc;
        t = model_tile(10, 20);
        exp_tile[95:0] = t[95:0];
        chk("tmo_err_done", {oDONE, oERR}, 2'b11);
        chk("tmo_latency", dcyc, 256);
        chk("tmo_tile", oTILE, exp_tile);
        iSTART = 1'b0;
        @(negedge iCLK);
        chk("tmo_clear", {oDONE, oERR, oSTATE}, 0);
        drop_at = -1;

        // reset during WAIT of read 9, iSTART held high; stray valid afterwards
        mem_lat = 10;
        rd0 = rd_total;
        iROW = 9'd3;
        iCOL = 10'd7;
        iSTART = 1'b1;
        for (int k = 0; k < 500 && (rd_total - rd0) < 9; k++) @(negedge iCLK);
        repeat (2) @(negedge iCLK);
        chk("rst_in_wait", oSTATE, 3);
        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        chk("rst_outputs", {oDONE, oERR, oBUSY, oMEM_RD, oSTATE, oMEM_ADDR}, 0);
        chk("rst_tile", oTILE, 0);
        exp_tile = '0;
        iRST_N = 1'b1;
        rd0 = rd_total;
        repeat (15) @(negedge iCLK);
        chk("rst_no_restart", {oBUSY, oSTATE}, 0);
        chk("rst_no_reads", rd_total - rd0, 0);
        chk("rst_stray_ignored", oTILE, 0);
        mem_lat = 1;
        iSTART = 1'b0;
        @(negedge iCLK);
        do_fetch(3, 7, cyc);
        exp_tile = model_tile(3, 7);
        chk("rst_refetch_cycles", cyc, 34);
        chk("rst_refetch_tile", oTILE, exp_tile);
        iSTART = 1'b0;
        @(negedge iCLK);

        // handshake abuse: start toggled mid-fetch, then held after DONE
        rd0 = rd_total;
        iROW = 9'd20;
        iCOL = 10'd40;
        iSTART = 1'b1;
        repeat (10) @(negedge iCLK);
        iSTART = 1'b0;
        @(negedge iCLK);
        iSTART = 1'b1;
        for (int k = 0; k < 200 && !oDONE; k++) @(negedge iCLK);
        repeat (20) @(negedge iCLK);
        exp_tile = model_tile(20, 40);
        chk("abuse_done_held", {oDONE, oERR, oSTATE}, {2'b10, 3'd4});
        chk("abuse_single_fetch", rd_total - rd0, 16);
        chk("abuse_tile", oTILE, exp_tile);
        iSTART = 1'b0;
        @(negedge iCLK);
        chk("abuse_done_clear", oDONE, 0);
        repeat (5) @(negedge iCLK);
        chk("abuse_idle", {oBUSY, oSTATE}, 0);
        chk("abuse_no_extra_reads", rd_total - rd0, 16);
        chk("abuse_tile_kept", oTILE, exp_tile);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
